// File: rtl/ifetch.sv
// Instruction fetch stage: takes fetch addresses from the pc stage, issues
// single-outstanding requests to instruction memory and presents the returned
// word to decode with a valid/ready handshake. Flush discards in-flight and
// held instructions; a request still in flight after a flush is dropped when
// its data returns.
// Optional build macro IFETCH_MISALIGN_EN: an accepted pc with pc[1:0]!=0 is
// not sent to memory and is presented as a NOP flagged by inst_fault.
module ifetch #(
   parameter int              XLEN = 32,
   parameter logic [XLEN-1:0] NOP  = XLEN'(32'h0000_0013)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   input  logic            pc_valid,
   output logic            pc_ready,
   input  logic            flush,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   output logic            inst_valid,
   input  logic            inst_ready,
   output logic            inst_fault
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_WAIT  = 2'd1;
   localparam logic [1:0] S_VALID = 2'd2;
   localparam logic [1:0] S_DROP  = 2'd3;

   logic [1:0]      state_q, state_d;
   logic [XLEN-1:0] pend_q, pend_d;
   logic [XLEN-1:0] inst_q, inst_d;
   logic [XLEN-1:0] inst_pc_q, inst_pc_d;
   logic            accept;
   logic            misalign;

   // A new address is taken only when nothing is outstanding or the held
   // instruction leaves this cycle; this keeps one request in flight at most.
   assign accept = pc_valid & ~flush &
                   ((state_q == S_IDLE) | ((state_q == S_VALID) & inst_ready));

`ifdef IFETCH_MISALIGN_EN
   logic fault_q, fault_d;

   assign misalign = (pc[1:0] != 2'b00);

   // Fault marker lives exactly as long as the misaligned entry it tags.
   always_comb begin
      fault_d = (accept & misalign) |
                (fault_q & (state_q == S_VALID) & ~flush & ~inst_ready);
   end

   // Fault marker register.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) fault_q <= 1'b0;
      else        fault_q <= fault_d;
   end

   assign inst_fault = fault_q;
`else
   assign misalign   = 1'b0;
   assign inst_fault = 1'b0;
`endif

   assign pc_ready   = accept;
   assign imem_req   = accept & ~misalign;
   assign imem_addr  = pc;
   assign inst_valid = (state_q == S_VALID);
   // inst_q is reloaded with NOP on every path out of VALID, so it already
   // reads as NOP whenever inst_valid is low.
   assign inst       = inst_q;

   // Next-state and datapath decisions for the fetch FSM.
   always_comb begin
      // NOTE: every _d starts as its _q so paths that do not assign it hold state instead of inferring a latch.
      state_d   = state_q;
      pend_d    = pend_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      case (state_q)
         S_IDLE, S_VALID: begin
            if (flush) begin
               state_d = S_IDLE;
               inst_d  = NOP;
            end else if (accept) begin
               inst_d = NOP;
               if (misalign) begin
                  state_d   = S_VALID;
                  inst_pc_d = pc;
               end else begin
                  state_d = S_WAIT;
                  pend_d  = pc;
               end
            end else if ((state_q == S_VALID) && inst_ready) begin
               state_d = S_IDLE;
               inst_d  = NOP;
            end
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               if (flush) begin
                  state_d = S_IDLE;
               end else begin
                  state_d   = S_VALID;
                  inst_d    = imem_rdata;
                  inst_pc_d = pend_q;
               end
            end else if (flush) begin
               state_d = S_DROP;
            end
         end
         default: begin
            // DROP: the stale response retires the outstanding request even
            // when another flush arrives alongside it; a flush alone waits.
            if (imem_rvalid) state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         pend_q    <= '0;
         inst_q    <= NOP;
         inst_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pend_q    <= pend_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
      end
   end

   assign inst_pc = inst_pc_q;

endmodule

// File: tb/tb_ifetch.sv
// Scoreboard bench for ifetch: a memory responder answers each request after
// a fixed or random latency, accepted addresses push their expected entry and
// a monitor pops and compares whenever decode consumes an instruction.
module tb_ifetch;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc = '0;
   logic        pc_valid = 1'b0;
   logic        pc_ready;
   logic        flush = 1'b0;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_valid;
   logic        inst_ready = 1'b0;
   logic        inst_fault;

   ifetch #(.XLEN(32), .NOP(NOP)) dut (
      .clock(clock), .reset(reset), .pc(pc), .pc_valid(pc_valid),
      .pc_ready(pc_ready), .flush(flush), .imem_req(imem_req),
      .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
      .imem_rdata(imem_rdata), .inst(inst), .inst_pc(inst_pc),
      .inst_valid(inst_valid), .inst_ready(inst_ready),
      .inst_fault(inst_fault)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] word;
      logic        fault;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;
   int   consumed = 0;
   int   lat_fix = 1;
   logic busy = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, req, $time);
      end
   endtask

   // Memory contents: two fixed words for the directed scenarios, a hash elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h100) return 32'h0050_0093;
      if (a == 32'h200) return 32'hDEAD_BEEF;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
   endfunction

   // What decode must eventually see for an accepted address.
   function automatic exp_t model(input logic [31:0] a);
      exp_t e;
      e = '{addr: a, word: mem_word(a), fault: 1'b0};
`ifdef IFETCH_MISALIGN_EN
      if (a[1:0] != 2'b00) e = '{addr: a, word: NOP, fault: 1'b1};
`endif
      return e;
   endfunction

   // Memory responder: one answer per request, after lat_fix cycles (0 = random 1..3).
   initial begin : responder
      logic [31:0] resp_addr;
      int          resp_cnt;
      resp_addr   = '0;
      resp_cnt    = 0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      forever begin
         @(negedge clock);
         if (imem_req === 1'b1) begin
            check("one_outstanding", 32'(busy), 32'd0);
            busy      = 1'b1;
            resp_addr = imem_addr;
            resp_cnt  = (lat_fix > 0) ? lat_fix : int'($urandom_range(3, 1));
         end
         @(posedge clock);
         #1;
         imem_rvalid = 1'b0;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               imem_rvalid = 1'b1;
               imem_rdata  = mem_word(resp_addr);
               busy        = 1'b0;
            end
         end
      end
   end

   // Stimulus observer: every accepted address pushes its expected entry.
   initial begin : observer
      forever begin
         @(negedge clock);
         if (reset && pc_valid && pc_ready) exp_q.push_back(model(pc));
      end
   end

   // Monitor: compare on each consumption; flush and reset discard everything pending.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset) begin
            exp_q.delete();
         end else begin
            if (inst_valid) begin
               if (inst_ready) begin
                  if (exp_q.size() == 0) begin
                     check("sb_unexpected_inst", inst_pc, 32'hFFFF_FFFF);
                  end else begin
                     e = exp_q.pop_front();
                     check("sb_inst", inst, e.word);
                     check("sb_inst_pc", inst_pc, e.addr);
                     check("sb_inst_fault", 32'(inst_fault), 32'(e.fault));
                     consumed++;
                  end
               end
            end else begin
               check("nop_when_invalid", inst, NOP);
               check("fault_when_invalid", 32'(inst_fault), 32'd0);
            end
            if (flush) exp_q.delete();
         end
      end
   end

   task automatic drive(input logic v, input logic [31:0] a, input logic rdy, input logic fl);
      @(posedge clock);
      #1;
      pc_valid   = v;
      pc         = a;
      inst_ready = rdy;
      flush      = fl;
   endtask

   task automatic wait_valid(input string name);
      int n;
      n = 0;
      while (n < 20) begin
         @(negedge clock);
         if (inst_valid) break;
         n++;
      end
      if (n >= 20) check(name, 32'(inst_valid), 32'd1);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : driver
      // Reset state
      repeat (2) @(negedge clock);
      check("rst_inst", inst, NOP);
      check("rst_inst_pc", inst_pc, 32'd0);
      check("rst_inst_valid", 32'(inst_valid), 32'd0);
      check("rst_inst_fault", 32'(inst_fault), 32'd0);
      check("rst_imem_req", 32'(imem_req), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;

      // Basic fetch, minimum latency
      lat_fix = 1;
      drive(1'b1, 32'h100, 1'b1, 1'b0);
      @(negedge clock);
      check("a_req", 32'(imem_req), 32'd1);
      check("a_addr", imem_addr, 32'h100);
      check("a_pc_ready", 32'(pc_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      @(negedge clock);
      check("a_not_yet_valid", 32'(inst_valid), 32'd0);
      @(negedge clock);
      check("a_valid", 32'(inst_valid), 32'd1);
      check("a_inst", inst, 32'h0050_0093);
      check("a_inst_pc", inst_pc, 32'h100);
      @(negedge clock);
      check("a_idle_after", 32'(inst_valid), 32'd0);

      // Decode stall, then back-to-back request in the releasing cycle
      drive(1'b1, 32'h104, 1'b0, 1'b0);
      @(negedge clock);
      check("b_req", 32'(imem_req), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      @(negedge clock);
      check("b_valid", 32'(inst_valid), 32'd1);
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 32'h108, 1'b0, 1'b0);
         @(negedge clock);
         check("b_hold_inst", inst, mem_word(32'h104));
         check("b_hold_pc", inst_pc, 32'h104);
         check("b_hold_ready", 32'(pc_ready), 32'd0);
         check("b_hold_req", 32'(imem_req), 32'd0);
      end
      drive(1'b1, 32'h108, 1'b1, 1'b0);
      @(negedge clock);
      check("b_b2b_req", 32'(imem_req), 32'd1);
      check("b_b2b_addr", imem_addr, 32'h108);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("b_wait", 32'(inst_valid), 32'd0);
      @(negedge clock);
      check("b_second_pc", inst_pc, 32'h108);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("b_idle", 32'(inst_valid), 32'd0);

      // Flush while waiting, late data dropped
      lat_fix = 3;
      drive(1'b1, 32'h200, 1'b0, 1'b0);
      @(negedge clock);
      check("c_req", 32'(imem_req), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clock);
      check("c_flush_ready", 32'(pc_ready), 32'd0);
      drive(1'b1, 32'h300, 1'b0, 1'b0);
      @(negedge clock);
      check("c_drop_ready", 32'(pc_ready), 32'd0);
      check("c_drop_req", 32'(imem_req), 32'd0);
      @(negedge clock);
      check("c_drop_rvalid_ready", 32'(pc_ready), 32'd0);
      check("c_drop_rvalid_valid", 32'(inst_valid), 32'd0);
      @(negedge clock);
      check("c_idle_valid", 32'(inst_valid), 32'd0);
      check("c_idle_inst", inst, NOP);
      check("c_idle_ready", 32'(pc_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      wait_valid("c_timeout");
      check("c_next_pc", inst_pc, 32'h300);
      drive(1'b0, 32'h0, 1'b0, 1'b0);

      // Flush coincident with returning data
      lat_fix = 1;
      drive(1'b1, 32'h400, 1'b0, 1'b0);
      @(negedge clock);
      check("d_req", 32'(imem_req), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      @(negedge clock);
      drive(1'b1, 32'h404, 1'b0, 1'b0);
      @(negedge clock);
      check("d_valid", 32'(inst_valid), 32'd0);
      check("d_inst", inst, NOP);
      check("d_idle_ready", 32'(pc_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      wait_valid("d_timeout");
      check("d_next_pc", inst_pc, 32'h404);
      drive(1'b0, 32'h0, 1'b0, 1'b0);

      // Reset while waiting, late response after release
      lat_fix = 3;
      drive(1'b1, 32'h500, 1'b0, 1'b0);
      @(negedge clock);
      check("e_req", 32'(imem_req), 32'd1);
      @(posedge clock);
      #1;
      pc_valid = 1'b0;
      reset    = 1'b0;
      @(negedge clock);
      check("e_rst_inst", inst, NOP);
      check("e_rst_pc", inst_pc, 32'd0);
      check("e_rst_valid", 32'(inst_valid), 32'd0);
      check("e_rst_fault", 32'(inst_fault), 32'd0);
      @(posedge clock);
      #1;
      reset = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clock);
         check("e_post_valid", 32'(inst_valid), 32'd0);
         check("e_post_inst", inst, NOP);
         check("e_post_pc", inst_pc, 32'd0);
         check("e_post_req", 32'(imem_req), 32'd0);
      end

`ifdef IFETCH_MISALIGN_EN
      // Misaligned fetch becomes a fault-tagged NOP without touching memory
      lat_fix = 1;
      drive(1'b1, 32'h102, 1'b0, 1'b0);
      @(negedge clock);
      check("f_no_req", 32'(imem_req), 32'd0);
      check("f_ready", 32'(pc_ready), 32'd1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("f_valid", 32'(inst_valid), 32'd1);
      check("f_fault", 32'(inst_fault), 32'd1);
      check("f_pc", inst_pc, 32'h102);
      check("f_inst", inst, 32'h0000_0013);
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("f_fault_cleared", 32'(inst_fault), 32'd0);
      drive(1'b1, 32'h106, 1'b0, 1'b0);
      drive(1'b0, 32'h0, 1'b0, 1'b1);
      drive(1'b0, 32'h0, 1'b0, 1'b0);
      @(negedge clock);
      check("f_flush_fault", 32'(inst_fault), 32'd0);
      check("f_flush_valid", 32'(inst_valid), 32'd0);
`endif

      // Randomised traffic against the scoreboard
      lat_fix = 0;
      for (int i = 0; i < 800; i++) begin
         logic        v, rdy, fl;
         logic [31:0] a;
         v   = ($urandom_range(9, 0) < 7);
         a   = $urandom & 32'h0000_FFFC;
         if ($urandom_range(7, 0) == 0) a[1:0] = 2'($urandom_range(3, 1));
         fl  = ($urandom_range(19, 0) == 0);
         rdy = fl ? 1'b0 : ($urandom_range(9, 0) < 6);
         drive(v, a, rdy, fl);
      end
      drive(1'b0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 50; i++) begin
         @(negedge clock);
         if (exp_q.size() == 0 && !busy) break;
      end
      check("drain_empty", 32'(exp_q.size()), 32'd0);
      check("random_consumed", 32'(consumed > 40), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 SHALL have parameter XLEN, default 32, which sets the address and data width.
REQ-002 SHALL have parameter [XLEN-1:0] NOP, default 32'h00000013, which is the instruction word presented when nothing valid is held.
REQ-003 SHALL have port clock, input, 1 bit: the single clock, with all state updating on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port pc, input, XLEN bits: the fetch address from the pc stage.
REQ-006 SHALL have port pc_valid, input, 1 bit: pc holds an address to fetch.
REQ-007 SHALL have port pc_ready, output, 1 bit: the address is accepted this cycle, so the pc stage may advance.
REQ-008 SHALL have port flush, input, 1 bit: a redirect that discards in-flight and held instructions.
REQ-009 SHALL have port imem_req, output, 1 bit: instruction memory request strobe, one cycle per request.
REQ-010 SHALL have port imem_addr, output, XLEN bits: the request address.
REQ-011 SHALL have port imem_rvalid, input, 1 bit: read data is returning.
REQ-012 SHALL have port imem_rdata, input, XLEN bits: the returned instruction word.
REQ-013 SHALL have port inst, output, XLEN bits: the instruction sent to decode.
REQ-014 SHALL have port inst_pc, output, XLEN bits: the address of inst.
REQ-015 SHALL have port inst_valid, output, 1 bit: inst and inst_pc are valid.
REQ-016 SHALL have port inst_ready, input, 1 bit: decode consumes inst this cycle.
REQ-017 SHALL have port inst_fault, output, 1 bit: inst is a misaligned-fetch fault marker.

Function
REQ-018 SHALL implement FSM states IDLE, WAIT, VALID and DROP.
REQ-019 SHALL define accept = pc_valid & ~flush & (state==IDLE | (state==VALID & inst_ready)); pc_ready = accept; imem_req = accept; imem_addr = pc (all combinational).
REQ-020 SHALL, on accept, latch pc into a pending-address register and enter WAIT.
REQ-021 SHALL, in WAIT with imem_rvalid & ~flush, register imem_rdata into inst and the pending address into inst_pc, set inst_valid next cycle, and enter VALID (minimum latency req->inst_valid is 2 cycles).
REQ-022 SHALL, in VALID, hold inst, inst_pc and inst_valid stable while inst_ready=0.
REQ-023 SHALL, in VALID with inst_ready=1, go to WAIT if accept is asserted (back-to-back fetch), else go to IDLE with inst_valid=0.
REQ-024 SHALL, on flush in IDLE or VALID, go to IDLE with inst_valid=0 next cycle and issue no request that cycle.
REQ-025 SHALL, on flush in WAIT without imem_rvalid, enter DROP; on flush in WAIT with imem_rvalid, discard the data and enter IDLE.
REQ-026 SHALL, in DROP, deassert pc_ready, discard the next imem_rvalid, then enter IDLE; flush in DROP keeps the state DROP.
REQ-027 SHALL ignore imem_rvalid in IDLE and VALID.
REQ-028 SHALL drive inst = NOP whenever inst_valid=0.
REQ-029 SHALL allow at most one outstanding memory request at any time.

Reset
REQ-030 SHALL, asynchronously while reset=0, force state=IDLE, inst=NOP, inst_pc=0, inst_valid=0, inst_fault=0 and the pending-address register to 0.
REQ-031 SHALL, when reset asserts in WAIT, make the block drop the outstanding request; an imem_rvalid after reset release SHALL be ignored per REQ-027.

Configuration
REQ-032 SHALL, with IFETCH_MISALIGN_EN defined, treat an accepted pc with pc[1:0]!=0 as misaligned: imem_req=0, and next cycle state=VALID, inst=NOP, inst_pc=pc, inst_fault=1; inst_fault clears when that entry is consumed or flushed.
REQ-033 SHALL, without IFETCH_MISALIGN_EN, tie inst_fault to 0 and issue every accepted pc unmodified.

Verification
REQ-034 SHALL be verified with this scenario: pc=0x100 with pc_valid=1, rvalid one cycle after req with rdata=0x00500093, inst_ready=1 -> inst=0x00500093, inst_pc=0x100, inst_valid=1 two cycles after req.
REQ-035 SHALL be verified with this scenario: inst_ready=0 for 3 cycles while in VALID -> inst/inst_pc stable, pc_ready=0, imem_req=0; then inst_ready=1 with pc_valid=1 -> req for the next pc in that same cycle.
REQ-036 SHALL be verified with this scenario: flush one cycle after req, rvalid two cycles later with 0xDEADBEEF -> the data is never presented, inst=NOP, and the state returns to IDLE after rvalid.
REQ-037 SHALL be verified with this scenario: flush coincident with rvalid in WAIT -> the data is discarded, inst_valid=0, and state=IDLE next cycle.
REQ-038 SHALL be verified with this scenario: reset asserted in WAIT, then a late rvalid after release -> all outputs at reset values and inst_valid stays 0.
REQ-039 SHALL be verified with this scenario: with IFETCH_MISALIGN_EN defined, pc=0x102 -> no imem_req, and next cycle inst_fault=1, inst_pc=0x102, inst=0x00000013.
